// File: rtl/keypad_digit_entry_if.sv
// Keypad-side and digit-register-side signal bundle for keypad_digit_entry.
//
// Handshake: KEY_VALID is a one-cycle strobe and has no ready. The sink must
// take KEY in the cycle KEY_VALID is high. SL/LeftIn form a fixed 4-beat burst
// that the digit register cannot stall. CLR is a one-cycle pulse.
interface keypad_digit_entry_if;
   logic [3:0] ROW;        // keypad rows, active-low, asynchronous
   logic [3:0] COL;        // column drive, active-low one-cold
   logic       SL;         // shift-enable to the digit register
   logic       LeftIn;     // serial data bit, MSB first
   logic       CLR;        // clear pulse to the digit register
   logic [3:0] KEY;        // last accepted key code
   logic       KEY_VALID;  // strobe when a press is accepted
   logic       BUSY;       // high whenever the FSM is not scanning
   logic [2:0] state_dbg;  // FSM state, for observation only

   // Keypad/bench side: drives the rows, watches everything else
   modport master (
      output ROW,
      input  COL, SL, LeftIn, CLR, KEY, KEY_VALID, BUSY, state_dbg
   );

   // Entry block side
   modport slave (
      input  ROW,
      output COL, SL, LeftIn, CLR, KEY, KEY_VALID, BUSY, state_dbg
   );
endinterface

// File: rtl/keypad_digit_entry.sv
// 4x4 matrix keypad scanner with debounce. Digit keys are shifted MSB-first
// into a 4-bit digit register over SL/LeftIn; key 15 pulses CLR.
module keypad_digit_entry #(
   parameter int SCAN_DIV = 1000,  // clocks per column dwell, >= 4
   parameter int DEBOUNCE = 4      // matching dwell samples to accept, >= 1
) (
   input logic                 CLK,
   input logic                 RST,
   keypad_digit_entry_if.slave bus
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);

   // Encoding is stable so state_dbg can be decoded by a checker
   typedef enum logic [2:0] {
      S_SCAN     = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_SHIFT    = 3'd2,
      S_CLRK     = 3'd3,
      S_RELEASE  = 3'd4
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [DW-1:0]   div_q;
   logic [1:0]      col_q;
   logic [3:0]      row_meta;
   logic [3:0]      row_sync;
   logic [3:0]      pat_q;
   logic [1:0]      row_idx_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      bit_q;
   logic [3:0]      key_q;

   logic            dwell_end;
   logic            row_idle;
   logic            row_match;
   logic            cnt_last;
   logic            accept;
   logic            col_advance;
   logic [1:0]      low_row;
   logic [3:0]      accept_code;

   // The sample is taken only on the last cycle of each column dwell
   assign dwell_end   = (div_q == DW'(SCAN_DIV - 1));
   assign row_idle    = (row_sync == 4'hF);
   assign row_match   = (row_sync == pat_q);
   assign cnt_last    = (cnt_q == CW'(DEBOUNCE - 1));
   assign accept_code = {row_idx_q, col_q};
   assign accept      = (state_q == S_DEBOUNCE) && dwell_end && row_match && cnt_last;

   // Column moves on after an idle scan, a failed debounce, or a completed release
   assign col_advance = dwell_end &&
                        (((state_q == S_SCAN) && row_idle) ||
                         ((state_q == S_DEBOUNCE) && !row_match) ||
                         ((state_q == S_RELEASE) && row_idle && cnt_last));

   // Lowest-index low row wins when several keys in one column are down
   always_comb begin
      low_row = 2'd3;
      if (!row_sync[0])      low_row = 2'd0;
      else if (!row_sync[1]) low_row = 2'd1;
      else if (!row_sync[2]) low_row = 2'd2;
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_SCAN;
      else     state_q <= state_d;
   end

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SCAN: begin
            if (dwell_end && !row_idle) state_d = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (dwell_end) begin
               if (!row_match) begin
                  state_d = S_SCAN;
               end else if (cnt_last) begin
                  if (accept_code <= 4'd9)       state_d = S_SHIFT;
                  else if (accept_code == 4'd15) state_d = S_CLRK;
                  else                           state_d = S_RELEASE;
               end
            end
         end
         S_SHIFT: begin
            if (bit_q == 2'd3) state_d = S_RELEASE;
         end
         S_CLRK: begin
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            if (dwell_end && row_idle && cnt_last) state_d = S_SCAN;
         end
         default: state_d = S_SCAN;
      endcase
   end

   // Row synchroniser; idles high like the pulled-up pins
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= bus.ROW;
         row_sync <= row_meta;
      end
   end

   // Free-running dwell counter and column index
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q <= '0;
         col_q <= 2'd0;
      end else begin
         if (dwell_end) div_q <= '0;
         else           div_q <= div_q + DW'(1);
         if (col_advance) col_q <= col_q + 2'd1;
      end
   end

   // Press capture, debounce/release counter, shift bit counter, key register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pat_q     <= 4'hF;
         row_idx_q <= 2'd0;
         cnt_q     <= '0;
         bit_q     <= 2'd0;
         key_q     <= 4'd0;
      end else begin
         if ((state_q == S_SCAN) && dwell_end && !row_idle) begin
            pat_q     <= row_sync;
            row_idx_q <= low_row;
         end

         // Count restarts on every state change; otherwise it tracks samples
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (dwell_end) begin
            if (state_q == S_DEBOUNCE) begin
               cnt_q <= cnt_q + CW'(1);
            end else if (state_q == S_RELEASE) begin
               if (row_idle) cnt_q <= cnt_q + CW'(1);
               else          cnt_q <= '0;
            end
         end

         if (state_q == S_SHIFT) bit_q <= bit_q + 2'd1;
         else                    bit_q <= 2'd0;

         if (accept) key_q <= accept_code;
      end
   end

   // Outputs; KEY shows the new code already in the KEY_VALID cycle
   always_comb begin
      bus.COL       = ~(4'b0001 << col_q);
      bus.SL        = (state_q == S_SHIFT);
      bus.LeftIn    = (state_q == S_SHIFT) ? key_q[2'd3 - bit_q] : 1'b0;
      bus.CLR       = (state_q == S_CLRK);
      bus.KEY_VALID = accept;
      bus.KEY       = accept ? accept_code : key_q;
      bus.BUSY      = (state_q != S_SCAN);
      bus.state_dbg = state_q;
   end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with SCAN_DIV=4, DEBOUNCE=2.
// A small matrix model turns held keys into ROW levels from the driven COL.
module tb_keypad_digit_entry;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] keys_down = '0;
   logic [3:0]  row_drive;
   logic [3:0]  q_model = 4'h0;
   int          total = 0;
   int          bad = 0;
   int          kv_cnt = 0;
   int          sl_cnt = 0;
   int          clr_cnt = 0;

   keypad_digit_entry_if bus ();

   keypad_digit_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Keypad matrix: a held key pulls its row low while its column is driven
   always_comb begin
      row_drive = 4'hF;
      for (int k = 0; k < 16; k++)
         if (keys_down[k] && !bus.COL[k % 4]) row_drive[k / 4] = 1'b0;
   end
   assign bus.ROW = row_drive;

   // Downstream digit register model
   always @(posedge CLK) begin
      if (bus.CLR)     q_model <= 4'h0;
      else if (bus.SL) q_model <= {q_model[2:0], bus.LeftIn};
   end

   // Pulse counters sampled mid-cycle
   always @(negedge CLK) begin
      if (bus.KEY_VALID === 1'b1) kv_cnt++;
      if (bus.SL === 1'b1)        sl_cnt++;
      if (bus.CLR === 1'b1)       clr_cnt++;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic wait_key_valid(output bit found);
      found = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge CLK);
         if (bus.KEY_VALID === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(output bit found);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (bus.BUSY === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      total++; if (bus.COL !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", bus.COL); end
      total++; if ({bus.SL, bus.LeftIn, bus.CLR, bus.KEY_VALID, bus.BUSY} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.SL, bus.LeftIn, bus.CLR, bus.KEY_VALID, bus.BUSY});
      end
      total++; if (bus.KEY !== 4'h0) begin bad++; $display("FAIL reset_key got=%h exp=0", bus.KEY); end
      total++; if (bus.state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
      RST = 1'b0;
   endtask

   task automatic test_scan_reset();
      logic [3:0] exp_col;
      repeat (6) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      total++; if (bus.COL !== 4'b1110) begin bad++; $display("FAIL async_reset_col got=%b exp=1110", bus.COL); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b exp=0", bus.BUSY); end
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         total++; if (bus.COL !== exp_col) begin
            bad++; $display("FAIL scan_rotate k=%0d got=%b exp=%b", k, bus.COL, exp_col);
         end
      end
   endtask

   task automatic test_digit_shift();
      bit         found;
      int         kv0;
      logic [3:0] code = 4'h6;
      kv0 = kv_cnt;
      q_model = 4'h0;
      keys_down[6] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL key6_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'h6) begin bad++; $display("FAIL key6_code got=%h exp=6", bus.KEY); end
      for (int b = 0; b < 4; b++) begin
         @(negedge CLK);
         total++; if (bus.SL !== 1'b1) begin bad++; $display("FAIL key6_sl beat=%0d got=%b exp=1", b, bus.SL); end
         total++; if (bus.LeftIn !== code[3 - b]) begin
            bad++; $display("FAIL key6_bit beat=%0d got=%b exp=%b", b, bus.LeftIn, code[3 - b]);
         end
      end
      @(negedge CLK);
      total++; if (bus.SL !== 1'b0) begin bad++; $display("FAIL key6_sl_end got=%b exp=0", bus.SL); end
      total++; if (q_model !== 4'h6) begin bad++; $display("FAIL key6_q got=%h exp=6", q_model); end
      repeat (40) @(negedge CLK);
      keys_down = '0;
      wait_idle(found);
      total++; if (!found) begin bad++; $display("FAIL key6_idle got=busy exp=idle"); end
      total++; if (kv_cnt - kv0 !== 1) begin bad++; $display("FAIL key6_kv_count got=%0d exp=1", kv_cnt - kv0); end
   endtask

   task automatic test_bounce();
      int kv0;
      int sl0;
      kv0 = kv_cnt;
      sl0 = sl_cnt;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.COL !== 4'b1011) break;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.COL === 4'b1011) break;
      end
      keys_down[6] = 1'b1;
      repeat (4) @(negedge CLK);
      keys_down = '0;
      total++; if (bus.state_dbg !== 3'd1) begin bad++; $display("FAIL bounce_detect got=%0d exp=1", bus.state_dbg); end
      repeat (4) @(negedge CLK);
      total++; if (bus.COL !== 4'b0111) begin bad++; $display("FAIL bounce_next_col got=%b exp=0111", bus.COL); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL bounce_busy got=%b exp=0", bus.BUSY); end
      repeat (20) @(negedge CLK);
      total++; if (kv_cnt - kv0 !== 0) begin bad++; $display("FAIL bounce_kv got=%0d exp=0", kv_cnt - kv0); end
      total++; if (sl_cnt - sl0 !== 0) begin bad++; $display("FAIL bounce_sl got=%0d exp=0", sl_cnt - sl0); end
   endtask

   task automatic test_clear();
      bit found;
      int kv0;
      int sl0;
      int clr0;
      kv0 = kv_cnt; sl0 = sl_cnt; clr0 = clr_cnt;
      keys_down[15] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL clr_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'hF) begin bad++; $display("FAIL clr_code got=%h exp=f", bus.KEY); end
      @(negedge CLK);
      total++; if (bus.CLR !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b exp=1", bus.CLR); end
      @(negedge CLK);
      total++; if (bus.CLR !== 1'b0) begin bad++; $display("FAIL clr_pulse_end got=%b exp=0", bus.CLR); end
      keys_down = '0;
      wait_idle(found);
      total++; if (!found) begin bad++; $display("FAIL clr_idle got=busy exp=idle"); end
      total++; if (clr_cnt - clr0 !== 1) begin bad++; $display("FAIL clr_count got=%0d exp=1", clr_cnt - clr0); end
      total++; if (sl_cnt - sl0 !== 0) begin bad++; $display("FAIL clr_sl got=%0d exp=0", sl_cnt - sl0); end
      total++; if (kv_cnt - kv0 !== 1) begin bad++; $display("FAIL clr_kv got=%0d exp=1", kv_cnt - kv0); end
      total++; if (q_model !== 4'h0) begin bad++; $display("FAIL clr_q got=%h exp=0", q_model); end
   endtask

   task automatic test_hold();
      bit found;
      int kv0;
      int sl0;
      int clr0;
      kv0 = kv_cnt; sl0 = sl_cnt; clr0 = clr_cnt;
      keys_down[12] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL hold_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'hC) begin bad++; $display("FAIL hold_code got=%h exp=c", bus.KEY); end
      repeat (50 * SCAN_DIV) @(negedge CLK);
      total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", bus.BUSY); end
      total++; if (kv_cnt - kv0 !== 1) begin bad++; $display("FAIL hold_kv got=%0d exp=1", kv_cnt - kv0); end
      total++; if (sl_cnt - sl0 !== 0) begin bad++; $display("FAIL hold_sl got=%0d exp=0", sl_cnt - sl0); end
      total++; if (clr_cnt - clr0 !== 0) begin bad++; $display("FAIL hold_clr got=%0d exp=0", clr_cnt - clr0); end
      keys_down = '0;
      repeat (13) @(negedge CLK);
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL hold_release_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.KEY !== 4'hC) begin bad++; $display("FAIL hold_key_kept got=%h exp=c", bus.KEY); end
   endtask

   task automatic test_multikey();
      bit found;
      keys_down[2]  = 1'b1;
      keys_down[10] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL multi_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'h2) begin bad++; $display("FAIL multi_code got=%h exp=2", bus.KEY); end
      repeat (5) @(negedge CLK);
      total++; if (bus.SL !== 1'b0) begin bad++; $display("FAIL multi_sl_end got=%b exp=0", bus.SL); end
      total++; if (q_model !== 4'h2) begin bad++; $display("FAIL multi_q got=%h exp=2", q_model); end
      keys_down = '0;
      wait_idle(found);
      total++; if (!found) begin bad++; $display("FAIL multi_idle got=busy exp=idle"); end
   endtask

   task automatic test_reset_mid_shift();
      bit         found;
      logic [3:0] code = 4'h9;
      keys_down[9] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL abort_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'h9) begin bad++; $display("FAIL abort_code got=%h exp=9", bus.KEY); end
      @(negedge CLK);
      total++; if (bus.SL !== 1'b1) begin bad++; $display("FAIL abort_sl1 got=%b exp=1", bus.SL); end
      @(negedge CLK);
      total++; if (bus.SL !== 1'b1) begin bad++; $display("FAIL abort_sl2 got=%b exp=1", bus.SL); end
      #2 RST = 1'b1;
      keys_down = '0;
      #1;
      total++; if (bus.SL !== 1'b0) begin bad++; $display("FAIL abort_sl_drop got=%b exp=0", bus.SL); end
      total++; if (bus.state_dbg !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", bus.state_dbg); end
      total++; if (bus.KEY !== 4'h0) begin bad++; $display("FAIL abort_key got=%h exp=0", bus.KEY); end
      total++; if (bus.COL !== 4'b1110) begin bad++; $display("FAIL abort_col got=%b exp=1110", bus.COL); end
      @(negedge CLK);
      RST = 1'b0;
      keys_down[9] = 1'b1;
      wait_key_valid(found);
      total++; if (!found) begin bad++; $display("FAIL retry_valid got=timeout exp=pulse"); end
      total++; if (bus.KEY !== 4'h9) begin bad++; $display("FAIL retry_code got=%h exp=9", bus.KEY); end
      for (int b = 0; b < 4; b++) begin
         @(negedge CLK);
         total++; if (bus.SL !== 1'b1 || bus.LeftIn !== code[3 - b]) begin
            bad++; $display("FAIL retry_bit beat=%0d got=%b%b exp=1%b", b, bus.SL, bus.LeftIn, code[3 - b]);
         end
      end
      @(negedge CLK);
      total++; if (q_model !== 4'h9) begin bad++; $display("FAIL retry_q got=%h exp=9", q_model); end
      keys_down = '0;
      wait_idle(found);
      total++; if (!found) begin bad++; $display("FAIL retry_idle got=busy exp=idle"); end
   endtask

   initial begin
      test_reset();
      test_scan_reset();
      test_digit_shift();
      test_bounce();
      test_clear();
      test_hold();
      test_multikey();
      test_reset_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
